// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter: serialises CPU and DMA accesses, generates the SRAM
// strobe sequence with fixed wait states and returns a one-cycle ack plus read data.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_ce,
  output logic          mem_oe,
  output logic          mem_we,
  output logic          busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic PortCpu = 1'b0;
  localparam logic PortDma = 1'b1;

  localparam logic [3:0] LoadCnt = 4'(WAIT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    waitCnt_q, waitCnt_d;
  logic          lastGrant_q, lastGrant_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpuRdata_q, cpuRdata_d;
  logic [DW-1:0] dmaRdata_q, dmaRdata_d;

  logic cpuWins;
  logic inAccess;
  logic inResp;

  // Under contention the port that did not win last time takes the bus
  assign cpuWins = cpu_req && (!dma_req || (lastGrant_q == PortDma));

  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpuRdata_d  = cpuRdata_q;
    dmaRdata_d  = dmaRdata_q;
    case (state_q)
      StIdle: begin
        if (cpu_req || dma_req) begin
          owner_d     = cpuWins ? PortCpu : PortDma;
          lastGrant_d = cpuWins ? PortCpu : PortDma;
          we_d        = cpuWins ? cpu_we : dma_we;
          addr_d      = cpuWins ? cpu_addr : dma_addr;
          wdata_d     = cpuWins ? cpu_wdata : dma_wdata;
          waitCnt_d   = LoadCnt;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        waitCnt_d = waitCnt_q - 4'd1;
        if (waitCnt_q == 4'd0) begin
          state_d = StResp;
          if (!we_q) begin
            if (owner_q == PortCpu) cpuRdata_d = mem_rdata;
            else                    dmaRdata_d = mem_rdata;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      waitCnt_q   <= 4'd0;
      lastGrant_q <= PortDma;
      owner_q     <= PortCpu;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpuRdata_q  <= '0;
      dmaRdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpuRdata_q  <= cpuRdata_d;
      dmaRdata_q  <= dmaRdata_d;
    end
  end

  // Strobes and bus are only driven during ACCESS; RESP is the turnaround cycle
  assign inAccess  = (state_q == StAccess);
  assign inResp    = (state_q == StResp);
  assign mem_ce    = inAccess;
  assign mem_oe    = inAccess && !we_q;
  assign mem_we    = inAccess && we_q;
  assign mem_addr  = inAccess ? addr_q : '0;
  assign mem_wdata = inAccess ? wdata_q : '0;
  assign cpu_ack   = inResp && (owner_q == PortCpu);
  assign dma_ack   = inResp && (owner_q == PortDma);
  assign cpu_rdata = cpuRdata_q;
  assign dma_rdata = dmaRdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and
// random trials checked against a cycle-schedule model with its own memory image.
module tb_mem_arbiter;

  localparam int W  = 2;
  localparam int W4 = 4;

  logic        Clk;
  logic        Reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, dma_ack, mem_ce, mem_oe, mem_we, busy;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        rst4, c4Req, d4Req;
  logic        cpu_ack4, dma_ack4, mem_ce4, mem_oe4, mem_we4, busy4;
  logic [15:0] cpu_rdata4, dma_rdata4, mem_addr4, mem_wdata4;
  logic [15:0] mem_rdata4;

  logic [15:0] sram     [0:255];
  logic [15:0] modelMem [0:255];
  logic [15:0] expCpuRdata, expDmaRdata;
  int          modelLastGrant;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    bit          cReq;
    bit          cWe;
    logic [15:0] cAddr;
    logic [15:0] cData;
    bit          dReq;
    bit          dWe;
    logic [15:0] dAddr;
    logic [15:0] dData;
    int          expFirst;
    logic [15:0] expCpu;
    logic [15:0] expDma;
  } vec_t;

  vec_t vecs [6];

  mem_arbiter #(.WAIT_CYCLES(W), .AW(16), .DW(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we), .busy(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(W4), .AW(16), .DW(16)) dut4 (
    .Clk(Clk), .Reset(rst4),
    .cpu_req(c4Req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack4), .cpu_rdata(cpu_rdata4),
    .dma_req(d4Req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack4), .dma_rdata(dma_rdata4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4),
    .mem_ce(mem_ce4), .mem_oe(mem_oe4), .mem_we(mem_we4), .busy(busy4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign mem_rdata  = sram[mem_addr[7:0]];
  assign mem_rdata4 = 16'h0BAD;
  always @(posedge Clk) if (mem_ce && mem_we) sram[mem_addr[7:0]] <= mem_wdata;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One request pattern from an idle bus; expectations come from the grant schedule
  task automatic applyStimulus(input bit cReq, input bit cWe, input logic [15:0] cAddr,
                               input logic [15:0] cData, input bit dReq, input bit dWe,
                               input logic [15:0] dAddr, input logic [15:0] dData,
                               output int firstPort);
    int t0, gC, gD, cur;
    bit cAcc, dAcc, cResp, dResp;
    logic [5:0] expVec;
    cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cData;
    dma_we = dWe; dma_addr = dAddr; dma_wdata = dData;
    cpu_req = cReq; dma_req = dReq;
    t0 = cyc;
    gC = -100; gD = -100;
    if (cReq && dReq) begin
      if (modelLastGrant == 1) begin gC = t0; gD = t0 + W + 2; modelLastGrant = 1; end
      else begin gD = t0; gC = t0 + W + 2; modelLastGrant = 0; end
    end else if (cReq) begin
      gC = t0; modelLastGrant = 0;
    end else begin
      gD = t0; modelLastGrant = 1;
    end
    firstPort = -1;
    for (int k = 0; k < 2 * W + 6; k++) begin
      @(negedge Clk);
      cur   = cyc;
      cAcc  = (cur >= gC + 1) && (cur <= gC + W);
      dAcc  = (cur >= gD + 1) && (cur <= gD + W);
      cResp = (cur == gC + W + 1);
      dResp = (cur == gD + W + 1);
      if (cResp) begin
        if (cWe) modelMem[cAddr[7:0]] = cData;
        else     expCpuRdata = modelMem[cAddr[7:0]];
      end
      if (dResp) begin
        if (dWe) modelMem[dAddr[7:0]] = dData;
        else     expDmaRdata = modelMem[dAddr[7:0]];
      end
      expVec = {cResp, dResp, cAcc || dAcc, (cAcc && !cWe) || (dAcc && !dWe),
                (cAcc && cWe) || (dAcc && dWe), cAcc || dAcc || cResp || dResp};
      checkOutput("ackStrobeBusy", {cpu_ack, dma_ack, mem_ce, mem_oe, mem_we, busy}, expVec);
      if (cAcc || dAcc) begin
        checkOutput("memAddr", mem_addr, cAcc ? cAddr : dAddr);
        checkOutput("memWdata", mem_wdata, cAcc ? cData : dData);
      end
      checkOutput("cpuRdata", cpu_rdata, expCpuRdata);
      checkOutput("dmaRdata", dma_rdata, expDmaRdata);
      if (firstPort < 0 && (cpu_ack || dma_ack)) firstPort = dma_ack ? 1 : 0;
      @(posedge Clk); #1;
      if (cResp) cpu_req = 1'b0;
      if (dResp) dma_req = 1'b0;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  initial begin
    int  firstPort, t0, nAck, cCnt, dCnt, lastPort, expPort, found, waited;
    bit  reraiseC, reraiseD;
    int  order [8];

    Reset = 1'b1; rst4 = 1'b1; c4Req = 1'b0; d4Req = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      sram[i]     = 16'hC000 | 16'(i);
      modelMem[i] = 16'hC000 | 16'(i);
    end
    sram[16'h10] = 16'h1234;
    modelMem[16'h10] = 16'h1234;
    modelLastGrant = 1;
    expCpuRdata = '0;
    expDmaRdata = '0;

    vecs[0] = '{1, 0, 16'h0010, 16'h0000, 1, 1, 16'h00FF, 16'hBEEF, 0, 16'h1234, 16'h0000};
    vecs[1] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h00FF, 16'h0000, 1, 16'h1234, 16'hBEEF};
    vecs[2] = '{1, 1, 16'h0020, 16'h5555, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 16'hBEEF};
    vecs[3] = '{1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1, 16'h5555, 16'h1234};
    vecs[4] = '{1, 1, 16'h0030, 16'h0A0A, 1, 0, 16'h0030, 16'h0000, 1, 16'h5555, 16'hC030};
    vecs[5] = '{1, 0, 16'h0030, 16'h0000, 1, 1, 16'h0040, 16'h7777, 1, 16'h0A0A, 16'hC030};

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("resetCtrl", {cpu_ack, dma_ack, mem_ce, mem_oe, mem_we, busy}, 6'd0);
    checkOutput("resetBus", {mem_addr, mem_wdata}, 32'd0);
    checkOutput("resetRdata", {cpu_rdata, dma_rdata}, 32'd0);
    checkOutput("resetCtrl4", {cpu_ack4, dma_ack4, mem_ce4, mem_oe4, mem_we4, busy4}, 6'd0);
    checkOutput("resetRdata4", {cpu_rdata4, dma_rdata4}, 32'd0);
    checkOutput("resetBus4", {mem_addr4, mem_wdata4}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0; rst4 = 1'b0;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].cReq, vecs[v].cWe, vecs[v].cAddr, vecs[v].cData,
                    vecs[v].dReq, vecs[v].dWe, vecs[v].dAddr, vecs[v].dData, firstPort);
      checkOutput($sformatf("vec%0d.first", v), firstPort, vecs[v].expFirst);
      checkOutput($sformatf("vec%0d.cpuRdata", v), cpu_rdata, vecs[v].expCpu);
      checkOutput($sformatf("vec%0d.dmaRdata", v), dma_rdata, vecs[v].expDma);
    end

    // Request fields moving after the grant must not reach the SRAM bus
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    @(posedge Clk); #1;
    cpu_addr = 16'h0020;
    for (int k = 0; k < W; k++) begin
      @(negedge Clk);
      checkOutput("latchedAddr", {mem_ce, mem_oe, mem_addr}, {2'b11, 16'h0010});
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    expCpuRdata = modelMem[8'h10];
    checkOutput("latchedAck", {cpu_ack, dma_ack}, 2'b10);
    checkOutput("latchedRdata", cpu_rdata, expCpuRdata);
    @(posedge Clk); #1;
    cpu_req = 1'b0;
    modelLastGrant = 0;

    // Continuous contention: each port drops req for one cycle after its ack
    cpu_we = 1'b0; cpu_addr = 16'h0010; dma_we = 1'b0; dma_addr = 16'h00FF;
    cpu_req = 1'b1; dma_req = 1'b1;
    nAck = 0; cCnt = 0; dCnt = 0; reraiseC = 0; reraiseD = 0;
    for (int k = 0; k < 8 * (W + 2) + 16 && nAck < 8; k++) begin
      @(negedge Clk);
      checkOutput("noDualAck", {cpu_ack && dma_ack, mem_oe && mem_we}, 2'b00);
      lastPort = -1;
      if (cpu_ack) begin lastPort = 0; cCnt++; end
      else if (dma_ack) begin lastPort = 1; dCnt++; end
      if (lastPort >= 0) begin order[nAck] = lastPort; nAck++; end
      @(posedge Clk); #1;
      if (reraiseC) begin cpu_req = 1'b1; reraiseC = 0; end
      if (reraiseD) begin dma_req = 1'b1; reraiseD = 0; end
      if (lastPort == 0) begin cpu_req = 1'b0; reraiseC = (cCnt < 4); end
      if (lastPort == 1) begin dma_req = 1'b0; reraiseD = (dCnt < 4); end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checkOutput("altAckCount", nAck, 8);
    checkOutput("altPerPort", {16'(cCnt), 16'(dCnt)}, {16'd4, 16'd4});
    expPort = (modelLastGrant == 1) ? 0 : 1;
    for (int i = 0; i < 8 && i < nAck; i++) begin
      checkOutput($sformatf("altOrder%0d", i), order[i], expPort);
      expPort = 1 - expPort;
    end
    modelLastGrant = 1 - expPort;
    expCpuRdata = modelMem[8'h10];
    expDmaRdata = modelMem[8'hFF];
    repeat (2) @(posedge Clk); #1;
    checkOutput("altRdata", {cpu_rdata, dma_rdata}, {expCpuRdata, expDmaRdata});

    // Reset in the 2nd ACCESS cycle of a long CPU read abandons it without an ack
    cpu_we = 1'b0; cpu_addr = 16'h0010; c4Req = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    rst4 = 1'b1; c4Req = 1'b0;
    @(negedge Clk);
    checkOutput("rst4Access2", {mem_ce4, mem_oe4, mem_we4, busy4}, 4'b1101);
    @(posedge Clk); #1;
    rst4 = 1'b0;
    @(negedge Clk);
    checkOutput("rst4Idle", {cpu_ack4, dma_ack4, mem_ce4, mem_oe4, mem_we4, busy4}, 6'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      checkOutput("rst4NoAck", {cpu_ack4, dma_ack4, busy4}, 3'b000);
    end
    @(posedge Clk); #1;
    c4Req = 1'b1; d4Req = 1'b1;
    found = 0; waited = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      @(negedge Clk);
      waited = k;
      if (cpu_ack4 || dma_ack4) begin
        found = 1;
        checkOutput("rst4TieWinner", {cpu_ack4, dma_ack4}, 2'b10);
        checkOutput("rst4TieLatency", waited, W4 + 1);
      end
      @(posedge Clk); #1;
    end
    c4Req = 1'b0; d4Req = 1'b0;
    if (found == 0) checkOutput("rst4TieTimeout", 1, 0);

    repeat (2) @(posedge Clk); #1;
    for (int t = 0; t < 30; t++) begin
      int r;
      r = $urandom_range(1, 3);
      applyStimulus(r[0], 1'($urandom), 16'h0080 + 16'($urandom_range(0, 7)), 16'($urandom),
                    r[1], 1'($urandom), 16'h0080 + 16'($urandom_range(0, 7)), 16'($urandom),
                    firstPort);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
